// File: rtl/btn_reg_pkg.sv
// Shared constants for the button-driven shift/count register.
package btn_reg_pkg;

    // Encodings of the synchronised mode switch.
    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // Raw buttons are active-low, so the idle level is 1.
    localparam logic BTN_RELEASED = 1'b1;

    // 10 ms stability window at 27 MHz.
    localparam int unsigned DB_CYCLES_DEFAULT = 270000;

endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one active-low push button: 2-flop synchroniser, stability
// counter and a registered one-cycle pulse on each debounced press.
module btn_debounce
    import btn_reg_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_db_q;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    logic          w_differ;
    logic          w_fall;

    assign w_differ = (r_sync2 != r_db);
    // Debounced released->pressed only; the release direction is ignored.
    assign w_fall   = (r_db_q == BTN_RELEASED) && (r_db != BTN_RELEASED);

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= BTN_RELEASED;
            r_sync2 <= BTN_RELEASED;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: the debounced level follows only after DB_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_db  <= BTN_RELEASED;
        end else if (w_differ) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_db  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Delayed copy of the debounced level and the registered press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_q  <= BTN_RELEASED;
            r_press <= 1'b0;
        end else begin
            r_db_q  <= r_db;
            r_press <= w_fall;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/btn_shift_reg.sv
// Button-clocked register: each debounced press of btn_clk_n either shifts
// in the data button or counts up/down, depending on the mode switch.
module btn_shift_reg
    import btn_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_clk_n,
    input  logic             btn_d_n,
    input  logic             mode,
    output logic [WIDTH-1:0] led,
    output logic             evt
);

    logic             r_d_sync1;
    logic             r_d_sync2;
    logic             r_mode_sync1;
    logic             r_mode_sync2;
    logic [WIDTH-1:0] r_led;
    logic             r_evt;

    logic             w_press;
    logic             w_d;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_led_next;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_clk_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_clk_n),
        .press (w_press)
    );

    // Two-flop synchronisers for the data button and the mode switch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d_sync1    <= BTN_RELEASED;
            r_d_sync2    <= BTN_RELEASED;
            r_mode_sync1 <= MODE_SHIFT;
            r_mode_sync2 <= MODE_SHIFT;
        end else begin
            r_d_sync1    <= btn_d_n;
            r_d_sync2    <= r_d_sync1;
            r_mode_sync1 <= mode;
            r_mode_sync2 <= r_mode_sync1;
        end
    end

    assign w_d = ~r_d_sync2;

    // A one-bit register has nothing to shift, it just loads d.
    if (WIDTH == 1) begin : g_shift_w1
        assign w_shift = w_d;
    end else begin : g_shift_wn
        assign w_shift = {r_led[WIDTH-2:0], w_d};
    end

    // Up on d = 0, down on d = 1; natural wrap modulo 2^WIDTH.
    assign w_count = w_d ? (r_led - WIDTH'(1)) : (r_led + WIDTH'(1));

    // Select the update according to the mode seen in the event cycle.
    always_comb begin
        w_led_next = w_shift;
        if (r_mode_sync2 == MODE_COUNT) begin
            w_led_next = w_count;
        end
    end

    // Register update and event flag, both only on a press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
            r_evt <= 1'b0;
        end else begin
            r_evt <= w_press;
            if (w_press) begin
                r_led <= w_led_next;
            end
        end
    end

    assign led = r_led;
    assign evt = r_evt;

endmodule

// File: tb/tb_btn_shift_reg.sv
// Scoreboard bench for btn_shift_reg: WIDTH 5, 1 and 32 instances, DB_CYCLES 4.
module tb_btn_shift_reg;

    localparam int DB = 4;

    typedef struct {
        logic [31:0] led;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        bc5, bd5, md5;
    logic        bc1, bd1, md1;
    logic        bc32, bd32, md32;
    logic [4:0]  led5;
    logic [0:0]  led1;
    logic [31:0] led32;
    logic        evt5, evt1, evt32;

    int   cyc;
    int   checks;
    int   failures;
    exp_t q5[$];
    exp_t q1[$];
    exp_t q32[$];
    exp_t e5, e1, e32;

    btn_shift_reg #(.WIDTH(5), .DB_CYCLES(DB)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .btn_clk_n(bc5), .btn_d_n(bd5), .mode(md5),
        .led(led5), .evt(evt5)
    );
    btn_shift_reg #(.WIDTH(1), .DB_CYCLES(DB)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .btn_clk_n(bc1), .btn_d_n(bd1), .mode(md1),
        .led(led1), .evt(evt1)
    );
    btn_shift_reg #(.WIDTH(32), .DB_CYCLES(DB)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .btn_clk_n(bc32), .btn_d_n(bd32), .mode(md32),
        .led(led32), .evt(evt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input string name, input logic [31:0] act, input int act_cyc,
                             input exp_t e);
        checks++;
        if (act !== e.led || act_cyc != e.cyc) begin
            failures++;
            $display("FAIL %s: got led=%0h at cycle %0d, expected led=%0h at cycle %0d",
                     name, act, act_cyc, e.led, e.cyc);
        end
    endtask

    // Monitors: every evt pops one expectation and checks value and timing.
    always @(negedge clk) begin
        if (rst_n && evt5) begin
            if (q5.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt5_unexpected: got led=%0h at cycle %0d, expected no evt",
                         led5, cyc);
            end else begin
                e5 = q5.pop_front();
                check_evt("evt5", 32'(led5), cyc, e5);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && evt1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt1_unexpected: got led=%0h at cycle %0d, expected no evt",
                         led1, cyc);
            end else begin
                e1 = q1.pop_front();
                check_evt("evt1", 32'(led1), cyc, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && evt32) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt32_unexpected: got led=%0h at cycle %0d, expected no evt",
                         led32, cyc);
            end else begin
                e32 = q32.pop_front();
                check_evt("evt32", led32, cyc, e32);
            end
        end
    end

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int dut, input logic v);
        case (dut)
            5:       bc5  = v;
            1:       bc1  = v;
            default: bc32 = v;
        endcase
    endtask

    // One clean press: expected led value lands DB+3 edges after edge 0.
    task automatic press(input int dut, input logic d, input logic md, input logic [31:0] exp,
                         input int hold);
        exp_t e;
        case (dut)
            5:       begin bd5  = ~d; md5  = md; end
            1:       begin bd1  = ~d; md1  = md; end
            default: begin bd32 = ~d; md32 = md; end
        endcase
        tick(4);
        set_btn(dut, 1'b0);
        e.led = exp;
        e.cyc = cyc + 1 + DB + 3;
        case (dut)
            5:       q5.push_back(e);
            1:       q1.push_back(e);
            default: q32.push_back(e);
        endcase
        tick(hold);
        set_btn(dut, 1'b1);
        tick(DB + 8);
    endtask

    initial begin
        exp_t e;
        int   k;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        bc5 = 1'b1; bd5 = 1'b1; md5 = 1'b0;
        bc1 = 1'b1; bd1 = 1'b1; md1 = 1'b0;
        bc32 = 1'b1; bd32 = 1'b1; md32 = 1'b0;

        // Reset with both buttons pressed.
        #1;
        bc5 = 1'b0; bd5 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst_led", 32'(led5), 32'h0);
            check("rst_evt", 32'(evt5), 32'h0);
        end
        bc5 = 1'b1; bd5 = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(10);

        // Shift mode.
        press(5, 1'b1, 1'b0, 32'h01, 20);
        press(5, 1'b0, 1'b0, 32'h02, 100);

        // Bounce shorter than the window.
        bc5 = 1'b0; tick(3);
        bc5 = 1'b1; tick(1);
        bc5 = 1'b0; tick(3);
        bc5 = 1'b1; tick(20);
        check("bounce_led", 32'(led5), 32'h02);

        press(5, 1'b1, 1'b0, 32'h05, 20);
        press(5, 1'b1, 1'b0, 32'h0B, 20);

        // Mode flip alone must not touch led.
        md5 = 1'b1; tick(10);
        check("mode_hold", 32'(led5), 32'h0B);
        md5 = 1'b0; tick(5);

        press(5, 1'b1, 1'b0, 32'h17, 20);
        press(5, 1'b1, 1'b0, 32'h0F, 20);
        press(5, 1'b1, 1'b0, 32'h1F, 20);

        // Count mode with wrap both ways.
        press(5, 1'b0, 1'b1, 32'h00, 20);
        press(5, 1'b1, 1'b1, 32'h1F, 20);
        press(5, 1'b1, 1'b1, 32'h1E, 20);
        press(5, 1'b0, 1'b1, 32'h1F, 20);

        // Reset in the middle of a debounce, button kept pressed.
        md5 = 1'b0; bd5 = 1'b1;
        tick(4);
        bc5 = 1'b0;
        k = cyc;
        e.led = 32'h0;
        e.cyc = k + 6 + DB + 3;
        q5.push_back(e);
        tick(3);
        rst_n = 1'b0;
        tick(2);
        check("midrst_led", 32'(led5), 32'h0);
        rst_n = 1'b1;
        tick(30);
        bc5 = 1'b1;
        tick(DB + 8);

        // WIDTH = 1 shift.
        press(1, 1'b1, 1'b0, 32'h1, 20);
        press(1, 1'b0, 1'b0, 32'h0, 20);
        press(1, 1'b1, 1'b0, 32'h1, 20);

        // WIDTH = 32 count.
        press(32, 1'b1, 1'b1, 32'hFFFF_FFFF, 20);
        press(32, 1'b0, 1'b1, 32'h0000_0000, 20);
        press(32, 1'b0, 1'b1, 32'h0000_0001, 20);

        tick(30);
        check("q5_drained", 32'(q5.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q32_drained", 32'(q32.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_shift_reg.md
BTN_SHIFT_REG -- requirements
Module: btn_shift_reg

Interface
REQ-001 Parameter: WIDTH, 5, register and LED width; legal range 1..32.
REQ-002 Parameter: DB_CYCLES, 270000, debounce stability window in clk cycles (10 ms at 27 MHz); legal range >= 2.
REQ-003 Port: clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: btn_clk_n  input  1  raw asynchronous "clock" button, active-low (0 = pressed).
REQ-006 Port: btn_d_n  input  1  raw asynchronous data button, active-low; data bit d = ~synchronised btn_d_n.
REQ-007 Port: mode  input  1  asynchronous switch; 0 = MODE_SHIFT, 1 = MODE_COUNT.
REQ-008 Port: led  output  WIDTH  register contents, 1 = LED on.
REQ-009 Port: evt  output  1  one-cycle pulse in the cycle in which led takes a new value.

Function
REQ-010 btn_clk_n, btn_d_n and mode SHALL each pass through a 2-flop synchroniser before any use.
REQ-011 Debounce: the debounced clock-button level SHALL change only after the synchronised level has differed from it for DB_CYCLES consecutive cycles; any intervening match SHALL clear the stability counter to 0.
REQ-012 Press event: one-cycle internal pulse on a debounced released->pressed transition; a pressed->released transition SHALL generate no event.
REQ-013 Latency: for a clean press held steady from edge 0, led and evt SHALL update at edge DB_CYCLES+3, exactly.
REQ-014 Holding the button pressed indefinitely SHALL produce exactly one event.
REQ-015 Glitches shorter than DB_CYCLES cycles SHALL produce no event and no change on led.
REQ-016 MODE_SHIFT, on an event: led <= {led[WIDTH-2:0], d}; for WIDTH = 1, led <= d.
REQ-017 MODE_COUNT, on an event: led <= led + 1 if d = 0, led <= led - 1 if d = 1, modulo 2^WIDTH (all-ones + 1 -> 0, 0 - 1 -> all-ones).
REQ-018 d and mode SHALL be the synchronised values present in the event cycle; a change in the same cycle as the event SHALL not be seen until the next event.
REQ-019 Mode changes SHALL NOT alter led; they take effect at the next event only.
REQ-020 evt SHALL be 1 exactly in the cycle led updates, else 0; led SHALL hold its value between events.

Reset
REQ-021 While rst_n = 0 at a rising edge: led = 0, evt = 0, stability counter = 0, debounced level = released, and all synchroniser flops = released (1) for the buttons and 0 for mode.
REQ-022 Reset during debounce SHALL discard the pending press; a button still held after reset release SHALL produce an event exactly DB_CYCLES+3 edges after the first edge with rst_n = 1.
REQ-023 No asynchronous reset paths; rst_n itself SHALL not be synchronised inside this block.

Structure
REQ-024 Shared package btn_reg_pkg SHALL hold the MODE_SHIFT/MODE_COUNT encodings and the default DB_CYCLES constant.
REQ-025 Sub-module btn_debounce (synchroniser + stability counter + press-edge pulse, parameter DB_CYCLES) SHALL be instantiated once for btn_clk_n; btn_d_n and mode use plain 2-flop synchronisers in the top.
REQ-026 The stability counter width SHALL be $clog2(DB_CYCLES+1); no other arithmetic wider than WIDTH.

Verification (WIDTH = 5, DB_CYCLES = 4 unless stated)
REQ-027 Reset: rst_n = 0 for 5 cycles with both buttons pressed -> led = 00000, evt = 0 throughout.
REQ-028 Shift: mode = 0, btn_d_n = 0, btn_clk_n low from edge 0 -> led = 00001 and evt = 1 at edge 7 only; release, then press with btn_d_n = 1 -> led = 00010; hold 100 cycles -> no further evt.
REQ-029 Bounce: btn_clk_n low for 3 cycles, high for 1, low for 3, then high -> no evt, led unchanged.
REQ-030 Counter wrap: mode = 1, led = 11111, d = 0, press -> led = 00000; d = 1, press -> led = 11111.
REQ-031 Reset mid-debounce: press at edge 0, rst_n = 0 at edges 3..4, button held -> led = 00000, single evt at edge 5+7 = 12.
REQ-032 Parameter sweep: WIDTH = 1 shift (led follows d per event) and WIDTH = 32 count (0 - 1 -> 0xFFFFFFFF).
